// File: rtl/rock_pkg.sv
// Shared types and thresholds for the rocking supervisor.
// The state encoding is fixed so that existing debug tooling can decode it.
package rock_pkg;

    localparam int AMP_W  = 3;
    localparam int FREQ_W = 3;

    localparam logic [7:0] CRY_START = 8'd64;
    localparam logic [7:0] CRY_QUIET = 8'd16;
    localparam logic [7:0] CRY_HIGH  = 8'd200;
    localparam logic [7:0] HR_MIN    = 8'd60;
    localparam logic [7:0] HR_MAX    = 8'd180;

    localparam int LOST_TICKS  = 16;
    localparam int QUIET_TICKS = 32;
    localparam int HOLD_TICKS  = 8;

    localparam logic [1:0] MAX_RESTARTS = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRACK   = 3'd1,
        RAMP    = 3'd2,
        HOLD    = 3'd3,
        RESTART = 3'd4,
        FAULT   = 3'd5
    } state_t;

    function automatic logic [AMP_W-1:0] dec_sat(input logic [AMP_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/rock_persist.sv
// Tick-based persistence counter: done fires on the tick that completes
// LIMIT consecutive ticks of cond. Saturates; any quiet tick or clr clears it.
module rock_persist #(
    parameter int LIMIT = 16,
    parameter int W     = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic cond,
    input  logic clr,
    output logic done
);

    localparam logic [W-1:0] LIM  = W'(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            if (!cond)
                cnt <= '0;
            else if (cnt != LIM)
                cnt <= cnt + 1'b1;
        end
    end

    assign done = tick & cond & ~clr & (cnt >= LAST);

endmodule

// File: rtl/rock_supervisor.sv
// Sequencer between the rocking controller and the power-stage output:
// gates rocking on cry volume, ramps down on lost regulation, restarts or faults.
module rock_supervisor
    import rock_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [7:0]        huil_vol,
    input  logic [7:0]        hartslag,
    input  logic [AMP_W-1:0]  ctrl_amp,
    input  logic [FREQ_W-1:0] ctrl_freq,
    output logic [AMP_W-1:0]  amp,
    output logic [FREQ_W-1:0] freq,
    output logic              ctrl_restart,
    output logic              rocking,
    output logic              alarm
);

    localparam logic [2:0] HOLD_LAST = 3'(HOLD_TICKS - 1);

    state_t     state;
    state_t     nxt;
    logic [2:0] hcnt;
    logic [1:0] rcnt;

    logic bad;
    logic quiet;
    logic clr;
    logic loss_done;
    logic quiet_done;

    logic [AMP_W-1:0]  amp_dec;
    logic [FREQ_W-1:0] freq_dec;

    assign bad = (hartslag == 8'd0) | (hartslag < HR_MIN)
               | (hartslag > HR_MAX) | (huil_vol >= CRY_HIGH);
    assign quiet = huil_vol < CRY_QUIET;
    // Counters only run while tracking; RESTART clears them and drops its tick.
    assign clr = (state != TRACK);

    assign amp_dec  = dec_sat(amp);
    assign freq_dec = dec_sat(freq);

    rock_persist #(.LIMIT(LOST_TICKS), .W(5)) u_loss (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .cond  (bad),
        .clr   (clr),
        .done  (loss_done)
    );

    rock_persist #(.LIMIT(QUIET_TICKS), .W(6)) u_quiet (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .cond  (quiet),
        .clr   (clr),
        .done  (quiet_done)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:
                if (tick && huil_vol >= CRY_START)
                    nxt = TRACK;
            TRACK:
                if (loss_done)
                    nxt = RAMP;
                else if (quiet_done)
                    nxt = IDLE;
            RAMP:
                if (tick && amp_dec == '0 && freq_dec == '0)
                    nxt = HOLD;
            HOLD:
                if (tick && hcnt == HOLD_LAST)
                    nxt = (rcnt == MAX_RESTARTS) ? FAULT : RESTART;
            RESTART:
                nxt = TRACK;
            FAULT:
                nxt = FAULT;
            default:
                nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            amp          <= '0;
            freq         <= '0;
            ctrl_restart <= 1'b0;
            rocking      <= 1'b0;
            alarm        <= 1'b0;
            hcnt         <= '0;
            rcnt         <= '0;
        end else begin
            state        <= nxt;
            ctrl_restart <= (nxt == RESTART);
            rocking      <= (nxt == TRACK) | (nxt == RAMP) | (nxt == HOLD);
            alarm        <= (nxt == FAULT);

            if (state != HOLD)
                hcnt <= '0;
            else if (tick)
                hcnt <= hcnt + 1'b1;

            if (state == RESTART)
                rcnt <= rcnt + 1'b1;
            else if (state == TRACK && nxt == IDLE)
                rcnt <= '0;

            case (state)
                TRACK: begin
                    amp  <= (nxt == IDLE) ? '0 : ctrl_amp;
                    freq <= (nxt == IDLE) ? '0 : ctrl_freq;
                end
                RAMP: begin
                    if (tick) begin
                        amp  <= amp_dec;
                        freq <= freq_dec;
                    end
                end
                default: begin
                    amp  <= '0;
                    freq <= '0;
                end
            endcase
        end
    end

endmodule
